// File: rtl/ahb_lite_arb_pkg.sv
// Shared types for the AHB-Lite initiator arbiter: transfer-type encoding and the buffered address-phase record.
package ahb_lite_arb_pkg;

   localparam int unsigned HADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_e;

   typedef struct packed {
      logic [HADDR_W-1:0] haddr;
      htrans_e            htrans;
      logic               hwrite;
      logic [2:0]         hsize;
   } ahb_addr_phase_t;

   function automatic logic is_xfer(input htrans_e t);
      return (t == NONSEQ) || (t == SEQ);
   endfunction

endpackage

// File: rtl/ahb_lite_arb_hold_reg.sv
// Per-initiator hold register: buffers an address phase that could not be issued and flags it for replay.
module ahb_lite_arb_hold_reg
   import ahb_lite_arb_pkg::*;
(
   input  logic            hclk,
   input  logic            hreset_n,
   input  logic            load,
   input  logic            clr,
   input  ahb_addr_phase_t phase_d,
   output ahb_addr_phase_t phase_q,
   output logic            held
);

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n)  held <= 1'b0;
      else if (clr)   held <= 1'b0;
      else if (load)  held <= 1'b1;
   end

   // Payload is only meaningful while held=1, so it carries no reset.
   always_ff @(posedge hclk) begin
      if (load) phase_q <= phase_d;
   end

endmodule

// File: rtl/ahb_lite_initiator_arbiter.sv
// Shares one downstream AHB-Lite initiator port among NUM_INITIATORS requesters, buffering and replaying losers.
// Define AHB_LITE_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module ahb_lite_initiator_arbiter
   import ahb_lite_arb_pkg::*;
#(
   parameter int AHB_LITE_ADDR_WIDTH = 32,
   parameter int AHB_LITE_DATA_WIDTH = 32,
   parameter int NUM_INITIATORS      = 2,
   localparam int IDX_W              = $clog2(NUM_INITIATORS)
) (
   input  logic                                        hclk,
   input  logic                                        hreset_n,
   input  logic                                        force_bus_idle,
   input  logic [NUM_INITIATORS*AHB_LITE_ADDR_WIDTH-1:0] init_haddr_i,
   input  logic [NUM_INITIATORS*2-1:0]                 init_htrans_i,
   input  logic [NUM_INITIATORS-1:0]                   init_hwrite_i,
   input  logic [NUM_INITIATORS*3-1:0]                 init_hsize_i,
   input  logic [NUM_INITIATORS*AHB_LITE_DATA_WIDTH-1:0] init_hwdata_i,
   output logic [NUM_INITIATORS*AHB_LITE_DATA_WIDTH-1:0] init_hrdata_o,
   output logic [NUM_INITIATORS-1:0]                   init_hreadyout_o,
   output logic [NUM_INITIATORS-1:0]                   init_hresp_o,
   output logic [AHB_LITE_ADDR_WIDTH-1:0]              m_haddr_o,
   output logic [1:0]                                  m_htrans_o,
   output logic                                        m_hwrite_o,
   output logic [2:0]                                  m_hsize_o,
   output logic [AHB_LITE_DATA_WIDTH-1:0]              m_hwdata_o,
   input  logic [AHB_LITE_DATA_WIDTH-1:0]              m_hrdata_i,
   input  logic                                        m_hreadyout_i,
   input  logic                                        m_hresp_i,
   output logic [IDX_W-1:0]                            grant_o
);

   localparam int N  = NUM_INITIATORS;
   localparam int AW = AHB_LITE_ADDR_WIDTH;
   localparam int DW = AHB_LITE_DATA_WIDTH;

   ahb_addr_phase_t live_ph [N];
   ahb_addr_phase_t hold_ph [N];
   ahb_addr_phase_t sel_ph  [N];
   ahb_addr_phase_t m_ph;
   ahb_addr_phase_t g_ph;
   logic [N-1:0]     held, req, load, clr;
   logic             data_vld, err_kill, arb_en, locked, found, issue;
   logic [IDX_W-1:0] data_own, winner;

   for (genvar g = 0; g < N; g++) begin : g_hold
      ahb_lite_arb_hold_reg u_hold (
         .hclk     (hclk),
         .hreset_n (hreset_n),
         .load     (load[g]),
         .clr      (clr[g]),
         .phase_d  (live_ph[g]),
         .phase_q  (hold_ph[g]),
         .held     (held[g])
      );
   end

   assign err_kill = data_vld & m_hresp_i;
   assign arb_en   = hreset_n & m_hreadyout_i & ~force_bus_idle;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (data_vld && data_own == IDX_W'(i)) init_hreadyout_o[i] = m_hreadyout_i;
         else if (held[i])                        init_hreadyout_o[i] = 1'b0;
         else                                     init_hreadyout_o[i] = 1'b1;
         init_hresp_o[i] = data_vld & (data_own == IDX_W'(i)) & m_hresp_i;
      end
   end

   // The owner of an erroring data phase loses its next phase: it is neither issued nor buffered.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         live_ph[i].haddr  = HADDR_W'(init_haddr_i[i*AW +: AW]);
         live_ph[i].htrans = htrans_e'(init_htrans_i[2*i +: 2]);
         live_ph[i].hwrite = init_hwrite_i[i];
         live_ph[i].hsize  = init_hsize_i[3*i +: 3];
         sel_ph[i]         = held[i] ? hold_ph[i] : live_ph[i];
         req[i]            = (held[i] | (init_hreadyout_o[i] & is_xfer(live_ph[i].htrans)))
                             & ~(err_kill & (data_own == IDX_W'(i)));
      end
   end

`ifdef AHB_LITE_ARB_RR_EN
   logic [IDX_W-1:0] rr_ptr;
`endif

   always_comb begin
      winner = grant_o;
      found  = 1'b0;
      g_ph   = sel_ph[grant_o];
      locked = (held[grant_o] | init_hreadyout_o[grant_o])
               & ((g_ph.htrans == SEQ) | (g_ph.htrans == BUSY))
               & ~(err_kill & (data_own == grant_o));
      if (locked) begin
         found = 1'b1;
      end else begin
`ifdef AHB_LITE_ARB_RR_EN
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N;
            if (!found && req[idx]) begin
               winner = IDX_W'(idx);
               found  = 1'b1;
            end
         end
`else
         for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
               winner = IDX_W'(i);
               found  = 1'b1;
            end
         end
`endif
      end
   end

   assign issue = arb_en & found;
   assign m_ph  = issue ? sel_ph[winner] : '0;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         load[i] = req[i] & ~held[i] & ~(issue & (winner == IDX_W'(i)));
         clr[i]  = (issue & (winner == IDX_W'(i)) & held[i]) | (err_kill & (data_own == IDX_W'(i)));
      end
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         data_vld <= 1'b0;
         data_own <= '0;
         grant_o  <= '0;
      end else begin
         if (m_hreadyout_i) begin
            data_vld <= issue & is_xfer(m_ph.htrans);
            if (issue) data_own <= winner;
         end
         if (issue) grant_o <= winner;
      end
   end

`ifdef AHB_LITE_ARB_RR_EN
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n)                            rr_ptr <= '0;
      else if (issue && m_ph.htrans == NONSEQ)  rr_ptr <= IDX_W'((int'(winner) + 1) % N);
   end
`endif

   assign m_haddr_o     = AW'(m_ph.haddr);
   assign m_htrans_o    = m_ph.htrans;
   assign m_hwrite_o    = m_ph.hwrite;
   assign m_hsize_o     = m_ph.hsize;
   assign m_hwdata_o    = init_hwdata_i[data_own*DW +: DW];
   assign init_hrdata_o = {N{m_hrdata_i}};

endmodule
